// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// ALU operation codes, sequencer states and decode classes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SUBU = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
    } state_e;

    typedef enum logic [2:0] {
        C_RTYPE, C_ITYPE, C_LW, C_SW, C_J, C_JR, C_ILL
    } class_e;

endpackage

// File: rtl/mips_instr_decoder.sv
// Combinational instruction classifier: maps opcode/funct onto a decode
// class, the ALU operation and the immediate extension mode.
module mips_instr_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output class_e     cls,
    output logic [3:0] alu_ctrl,
    output logic       imm_zext
);

    always_comb begin
        cls      = C_ILL;
        alu_ctrl = ALU_ADD;
        imm_zext = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                cls = C_RTYPE;
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_SUBU: alu_ctrl = ALU_SUBU;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    FN_JR:   cls = C_JR;
                    default: cls = C_ILL;
                endcase
            end
            OP_J:    cls = C_J;
            OP_ADDI: cls = C_ITYPE;
            OP_SLTI: begin
                cls      = C_ITYPE;
                alu_ctrl = ALU_SLT;
            end
            OP_ANDI: begin
                cls      = C_ITYPE;
                alu_ctrl = ALU_AND;
                imm_zext = 1'b1;
            end
            OP_ORI: begin
                cls      = C_ITYPE;
                alu_ctrl = ALU_OR;
                imm_zext = 1'b1;
            end
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            default: cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_sequencer.sv
// Multicycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB control with a shared
// memory port and a bounded wait for the memory acknowledge.
module mips_multicycle_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int WAIT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src,
    output logic       imm_zext,
    output logic [3:0] alu_ctrl,
    output logic       reg_dst,
    output logic       reg_we,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err
);

    state_e            state_q, state_d;
    class_e            cls_q, cls_d;
    logic [3:0]        alu_q, alu_d;
    logic              zext_q, zext_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;

    class_e     dec_cls;
    logic [3:0] dec_alu;
    logic       dec_zext;

    mips_instr_decoder u_decoder (
        .opcode   (opcode),
        .funct    (funct),
        .cls      (dec_cls),
        .alu_ctrl (dec_alu),
        .imm_zext (dec_zext)
    );

    // Memory handshake: mem_req stays high in FETCH/MEM until the cycle in
    // which mem_ack pulses; that cycle completes the access. Acks seen in
    // any other state are ignored.
    logic              in_req;
    logic [WAIT_W-1:0] wait_inc;
    logic              timeout;
    state_e            boundary;

    assign in_req   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign wait_inc = wait_q + WAIT_W'(1);
    assign timeout  = in_req && !mem_ack && (wait_inc == WAIT_W'(ACK_TIMEOUT));
    assign boundary = run ? S_FETCH : S_IDLE;

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        alu_d     = alu_q;
        zext_d    = zext_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        wait_d    = (in_req && !mem_ack) ? wait_inc : '0;
        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_ERROR;
                    bus_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                cls_d  = dec_cls;
                alu_d  = dec_alu;
                zext_d = dec_zext;
                case (dec_cls)
                    C_J, C_JR: state_d = boundary;
                    C_ILL: begin
                        state_d   = S_ERROR;
                        illegal_d = 1'b1;
                    end
                    default:   state_d = S_EXEC;
                endcase
            end
            S_EXEC:  state_d = (cls_q == C_LW || cls_q == C_SW) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ack) begin
                    state_d = (cls_q == C_SW) ? boundary : S_WB;
                end else if (timeout) begin
                    state_d   = S_ERROR;
                    bus_err_d = 1'b1;
                end
            end
            S_WB:    state_d = boundary;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cls_q     <= C_RTYPE;
            alu_q     <= ALU_ADD;
            zext_q    <= 1'b0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_q     <= alu_d;
            zext_q    <= zext_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // DECODE acts on the live decoder output because the class register is
    // only loaded at the end of that cycle.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        alu_src    = 1'b0;
        imm_zext   = 1'b0;
        alu_ctrl   = ALU_ADD;
        reg_dst    = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ack;
                pc_we   = mem_ack;
            end
            S_DECODE: begin
                if (dec_cls == C_J || dec_cls == C_JR) begin
                    pc_we      = 1'b1;
                    pc_src     = (dec_cls == C_J) ? 2'd1 : 2'd2;
                    instr_done = 1'b1;
                end
            end
            S_EXEC: begin
                alu_ctrl = alu_q;
                alu_src  = (cls_q != C_RTYPE);
                imm_zext = zext_q;
            end
            S_MEM: begin
                mem_req    = 1'b1;
                addr_sel   = 1'b1;
                mem_we     = (cls_q == C_SW);
                instr_done = (cls_q == C_SW) && mem_ack;
            end
            S_WB: begin
                reg_we     = 1'b1;
                reg_dst    = (cls_q == C_RTYPE);
                mem_to_reg = (cls_q == C_LW);
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Scoreboard bench for the multicycle sequencer: the driver pushes the
// expected control word for each cycle it drives, the monitor checks it.
module tb_mips_multicycle_sequencer;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_src;
    logic       imm_zext;
    logic [3:0] alu_ctrl;
    logic       reg_dst;
    logic       reg_we;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;
  } ctl_t;

  localparam int W    = $bits(ctl_t);
  localparam int K_R  = 0;
  localparam int K_I  = 1;
  localparam int K_LW = 2;
  localparam int K_SW = 3;
  localparam int K_J  = 4;
  localparam int K_JR = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ack;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we;
  logic [1:0] pc_src;
  logic       alu_src, imm_zext;
  logic [3:0] alu_ctrl;
  logic       reg_dst, reg_we, mem_to_reg, instr_done, illegal, bus_err;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests  = 0;
  int           failed = 0;
  logic [W-1:0] act_w;
  ctl_t         zero;

  mips_multicycle_sequencer #(.ACK_TIMEOUT(15), .WAIT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .funct      (funct),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src    (alu_src),
    .imm_zext   (imm_zext),
    .alu_ctrl   (alu_ctrl),
    .reg_dst    (reg_dst),
    .reg_we     (reg_we),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign act_w = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src,
                  imm_zext, alu_ctrl, reg_dst, reg_we, mem_to_reg, instr_done,
                  illegal, bus_err};

  // monitor: one expected control word per driven cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests++;
      if (act_w !== e) begin
        failed++;
        $display("FAIL %s at %0t: got %h required %h", n, $time, act_w, e);
      end
    end
  end

  task automatic check_now(input logic ok, input string nm);
    tests++;
    if (ok !== 1'b1) begin
      failed++;
      $display("FAIL %s at %0t: outputs %h", nm, $time, act_w);
    end
  endtask

  // driver: called at posedge+1, drives this cycle and records its expectation
  task automatic step(input ctl_t e, input logic ack, input string nm);
    mem_ack = ack;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int kind,
                       input logic [3:0] ac, input logic zx, input int fw,
                       input int mw, input logic drop_run);
    opcode = op;
    funct  = fn;
    for (int i = 0; i < fw; i++)
      step('{mem_req: 1'b1, default: '0}, 1'b0, "fetch_wait");
    step('{mem_req: 1'b1, ir_we: 1'b1, pc_we: 1'b1, default: '0}, 1'b1, "fetch_ack");
    if (drop_run) run = 1'b0;
    if (kind == K_J) begin
      step('{pc_we: 1'b1, pc_src: 2'd1, instr_done: 1'b1, default: '0}, 1'b0, "decode_j");
    end else if (kind == K_JR) begin
      step('{pc_we: 1'b1, pc_src: 2'd2, instr_done: 1'b1, default: '0}, 1'b0, "decode_jr");
    end else begin
      step(zero, 1'b0, "decode");
      step('{alu_src: (kind != K_R), imm_zext: zx, alu_ctrl: ac, default: '0},
           1'b1, "exec_stray_ack");
      if (kind == K_LW || kind == K_SW) begin
        for (int i = 0; i < mw; i++)
          step('{mem_req: 1'b1, addr_sel: 1'b1, mem_we: (kind == K_SW), default: '0},
               1'b0, "mem_wait");
        step('{mem_req: 1'b1, addr_sel: 1'b1, mem_we: (kind == K_SW),
               instr_done: (kind == K_SW), default: '0}, 1'b1, "mem_ack");
      end
      if (kind != K_SW)
        step('{reg_we: 1'b1, reg_dst: (kind == K_R), mem_to_reg: (kind == K_LW),
               instr_done: 1'b1, default: '0}, 1'b0, "wb");
    end
  endtask

  initial begin
    zero    = '0;
    reset   = 1'b1;
    run     = 1'b0;
    mem_ack = 1'b0;
    opcode  = 6'h00;
    funct   = 6'h00;
    @(posedge clk);
    #1;
    check_now(act_w === '0, "reset_outputs_zero");
    step(zero, 1'b0, "reset_state");
    step(zero, 1'b1, "reset_ack_ignored");
    reset = 1'b0;
    step(zero, 1'b0, "idle_hold");
    run = 1'b1;
    step(zero, 1'b0, "idle_run");

    // op, funct, kind, alu, zext, fetch wait, mem wait, drop run
    instr(6'h00, 6'h20, K_R,  4'd0, 1'b0, 0, 0, 1'b0);  // add
    instr(6'h23, 6'h00, K_LW, 4'd0, 1'b0, 0, 3, 1'b0);  // lw, 3-cycle ack delay
    instr(6'h2B, 6'h00, K_SW, 4'd0, 1'b0, 1, 0, 1'b0);  // sw
    instr(6'h02, 6'h00, K_J,  4'd0, 1'b0, 0, 0, 1'b0);  // j
    instr(6'h00, 6'h08, K_JR, 4'd0, 1'b0, 0, 0, 1'b0);  // jr
    instr(6'h00, 6'h22, K_R,  4'd1, 1'b0, 0, 0, 1'b0);  // sub
    instr(6'h00, 6'h23, K_R,  4'd6, 1'b0, 0, 0, 1'b0);  // subu
    instr(6'h00, 6'h24, K_R,  4'd2, 1'b0, 0, 0, 1'b0);  // and
    instr(6'h00, 6'h25, K_R,  4'd3, 1'b0, 0, 0, 1'b0);  // or
    instr(6'h00, 6'h27, K_R,  4'd4, 1'b0, 0, 0, 1'b0);  // nor
    instr(6'h00, 6'h2A, K_R,  4'd5, 1'b0, 2, 0, 1'b0);  // slt
    instr(6'h08, 6'h00, K_I,  4'd0, 1'b0, 0, 0, 1'b0);  // addi
    instr(6'h0A, 6'h00, K_I,  4'd5, 1'b0, 0, 0, 1'b0);  // slti
    instr(6'h0C, 6'h00, K_I,  4'd2, 1'b1, 0, 0, 1'b0);  // andi
    instr(6'h0D, 6'h00, K_I,  4'd3, 1'b1, 0, 0, 1'b0);  // ori
    instr(6'h00, 6'h20, K_R,  4'd0, 1'b0, 0, 0, 1'b1);  // add, run dropped mid-way
    step(zero, 1'b1, "idle_after_stop");
    step(zero, 1'b0, "idle_after_stop2");

    // illegal opcode: sticky flag, no further requests, cleared by reset
    run = 1'b1;
    step(zero, 1'b0, "idle_run");
    opcode = 6'h3F;
    step('{mem_req: 1'b1, ir_we: 1'b1, pc_we: 1'b1, default: '0}, 1'b1, "fetch_ack");
    step(zero, 1'b0, "decode_ill");
    for (int i = 0; i < 3; i++)
      step('{illegal: 1'b1, default: '0}, i[0], "error_illegal");
    reset = 1'b1;
    step(zero, 1'b0, "reset_clears_illegal");
    reset = 1'b0;
    run   = 1'b0;
    step(zero, 1'b0, "idle_after_illegal");

    // fetch ack never arrives: 15 request cycles, then bus error
    run    = 1'b1;
    opcode = 6'h00;
    step(zero, 1'b0, "idle_run");
    for (int i = 0; i < 15; i++)
      step('{mem_req: 1'b1, default: '0}, 1'b0, "fetch_timeout_wait");
    check_now((bus_err === 1'b1) && (mem_req === 1'b0), "expired_wait_bus_err");
    for (int i = 0; i < 2; i++)
      step('{bus_err: 1'b1, default: '0}, 1'b0, "error_bus");
    reset = 1'b1;
    step(zero, 1'b0, "reset_clears_bus_err");
    reset = 1'b0;
    step(zero, 1'b0, "idle_run");

    // reset asserted mid-MEM must drop mem_req without waiting for a clock
    opcode = 6'h23;
    step('{mem_req: 1'b1, ir_we: 1'b1, pc_we: 1'b1, default: '0}, 1'b1, "fetch_ack");
    step(zero, 1'b0, "decode");
    step('{alu_src: 1'b1, default: '0}, 1'b0, "exec");
    step('{mem_req: 1'b1, addr_sel: 1'b1, default: '0}, 1'b0, "mem_wait");
    mem_ack = 1'b0;
    #1;
    reset = 1'b1;
    exp_q.push_back(zero);
    name_q.push_back("reset_mid_mem");
    @(posedge clk);
    #1;
    run = 1'b0;
    step(zero, 1'b0, "reset_hold");
    reset = 1'b0;
    step(zero, 1'b0, "idle_post_reset");

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_sequencer.md
Name: mips_multicycle_sequencer

Overview:
- Multicycle sequencer for the MIPS core: steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives every datapath enable and mux select.
- Shares the single memory port between instruction fetch and load/store, using a req/ack handshake with a bounded wait.
- Sits between the instruction register and the register file/ALU/memory. It replaces per-opcode Moore decoding with a sequenced control flow.

Parameters:
- ACK_TIMEOUT, 15, maximum cycles mem_req may stay high without mem_ack before a bus error.
- WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > ACK_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- run  in  1  1 = execute instructions; 0 = stop at the next instruction boundary.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- mem_ack  in  1  memory completion for the current request, 1-cycle pulse.
- mem_req  out  1  memory access request.
- mem_we  out  1  store strobe; only meaningful with mem_req.
- addr_sel  out  1  0 = PC, 1 = ALU result as memory address.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  PC write enable.
- pc_src  out  2  0 = PC+4, 1 = jump target {PC[31:28], IR[25:0], 2'b00}, 2 = rs.
- alu_src  out  1  0 = rt, 1 = immediate.
- imm_zext  out  1  1 = zero-extend immediate (andi, ori); 0 = sign-extend.
- alu_ctrl  out  4  ALU operation code (package constants).
- reg_dst  out  1  1 = rd, 0 = rt.
- reg_we  out  1  register file write enable.
- mem_to_reg  out  1  writeback source: 1 = memory data.
- instr_done  out  1  1-cycle pulse when an instruction retires.
- illegal  out  1  sticky: an unsupported opcode/funct was decoded.
- bus_err  out  1  sticky: memory ack timeout.

Behaviour:
- Reset (async): state = IDLE, wait counter = 0. All outputs are 0, including the sticky flags. Asserting reset mid-access drops mem_req in the same instant.
- Outputs are decoded from the state register plus a decode class register. The class register is loaded at the end of DECODE.
- Supported instructions:
  - R-type, opcode 0x00: add 0x20, sub 0x22, subu 0x23, and 0x24, or 0x25, nor 0x27, slt 0x2A, jr 0x08.
  - I/J-type: j 0x02, addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B.
- IDLE: if run=1, go to FETCH; else hold.
- FETCH:
  - Drive mem_req=1, addr_sel=0; hold until mem_ack.
  - On the ack cycle: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
- DECODE (1 cycle): latch the class.
  - j: pc_we=1, pc_src=1, instr_done=1, return to the boundary.
  - jr: pc_we=1, pc_src=2, instr_done=1, return to the boundary.
  - Illegal encoding: go to ERROR.
  - All other instructions: go to EXEC.
- EXEC (1 cycle):
  - Drive alu_ctrl and alu_src; alu_src=1 and sign/zero extension apply to I-types and lw/sw.
  - Drive imm_zext=1 for andi/ori.
  - lw/sw go to MEM; all other instructions go to WB.
- MEM:
  - Drive mem_req=1, addr_sel=1, mem_we=(sw); hold until mem_ack.
  - sw: assert instr_done on the ack cycle, then return to the boundary.
  - lw: go to WB.
- WB (1 cycle): reg_we=1; reg_dst=1 for R-type, 0 otherwise; mem_to_reg=1 for lw; instr_done=1; return to the boundary.
- Instruction boundary: go to FETCH if run=1, else IDLE. run is sampled only at the boundary; deasserting run mid-instruction completes that instruction.
- Latency with zero-wait memory (ack in the first request cycle):
  - j/jr: 2 cycles.
  - sw and R/I ALU instructions: 4 cycles.
  - lw: 5 cycles.
- Wait counter:
  - Clears on every state entry.
  - Increments each cycle that mem_req=1 and mem_ack=0.
  - When the counter reaches ACK_TIMEOUT: set bus_err=1, go to ERROR.
- A mem_ack arriving outside FETCH/MEM is ignored.
- ERROR: all enables are 0; illegal/bus_err stay set; the block leaves ERROR only on reset.
- alu_ctrl codes: ADD=0, SUB=1, AND=2, OR=3, NOR=4, SLT=5, SUBU=6.
  - lw/sw/addi use ADD; slti uses SLT; andi uses AND; ori uses OR.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct localparams;
  - alu_ctrl codes;
  - state encoding: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERROR;
  - decode class encoding: RTYPE, ITYPE, LW, SW, J, JR, ILL.
- Sub-module mips_instr_decoder: purely combinational (opcode, funct) -> class, alu_ctrl, imm_zext. The sequencer instantiates it and registers the class.

Test Plan:
- add (op 0x00, funct 0x20), ack in the first FETCH cycle -> ir_we+pc_we at cycle 1, alu_ctrl=0 in EXEC, reg_we=1 with reg_dst=1 and instr_done at cycle 4.
- lw (op 0x23), memory ack delayed 3 cycles in MEM -> mem_req/addr_sel=1 held 4 cycles, then WB with mem_to_reg=1, reg_dst=0; 8 cycles total.
- sw (op 0x2B) -> mem_we=1 only in MEM; no reg_we; instr_done on the MEM ack cycle.
- j (op 0x02) then jr (0x00/0x08) -> each retires in 2 cycles with pc_src=1 and pc_src=2 respectively.
- Illegal opcode 0x3F -> illegal=1 after DECODE, no further mem_req; reset clears the flag and returns to IDLE.
- mem_ack never arrives in FETCH with ACK_TIMEOUT=15 -> bus_err=1 after 15 request cycles. A separate check: reset asserted mid-MEM drops mem_req immediately, and run=0 mid-add finishes the add then enters IDLE.
